// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - 4-digit M:SS.t stopwatch controller with tenths prescaler and digit scan
module stopwatch_ctrl #(
    parameter logic [23:0] TICK_DIV = 24'd999_999,
    parameter logic [15:0] SCAN_DIV = 16'd9_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_lap,
    input  logic       btn_clear,
    input  logic [7:0] div_override,
    output logic [3:0] digit_bcd,
    output logic [3:0] digit_sel,
    output logic       running,
    output logic       lap_hold,
    output logic       tick
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    // button edge history
    logic        start_prev_q, start_prev_d;
    logic        lap_prev_q, lap_prev_d;
    logic        clear_prev_q, clear_prev_d;
    logic        press_start, press_lap, press_clear;

    // control state
    logic [1:0]  state_q, state_d;
    logic        snap_load;
    logic        zero_count;
    logic        counting;

    // tenths prescaler
    logic [23:0] compare;
    logic [23:0] presc_q, presc_d;
    logic        presc_hit;

    // BCD time digits: d0 tenths, d1 seconds, d2 tens of seconds, d3 minutes
    logic [3:0]  d0_q, d0_d;
    logic [3:0]  d1_q, d1_d;
    logic [3:0]  d2_q, d2_d;
    logic [3:0]  d3_q, d3_d;
    logic        carry0, carry1, carry2;
    logic [15:0] live_bcd;
    logic [15:0] snap_q, snap_d;
    logic [15:0] shown_bcd;

    // digit scan
    logic [15:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]  scan_idx_q, scan_idx_d;
    logic        scan_hit;

    // registered outputs
    logic [3:0]  digit_sel_q, digit_sel_d;
    logic [3:0]  digit_bcd_q, digit_bcd_d;
    logic        running_q, running_d;
    logic        lap_hold_q, lap_hold_d;
    logic        tick_q, tick_d;

    // Rising-edge detect against last cycle's button level
    always_comb begin
        start_prev_d = btn_start;
        lap_prev_d   = btn_lap;
        clear_prev_d = btn_clear;
        press_start  = btn_start & ~start_prev_q;
        press_lap    = btn_lap   & ~lap_prev_q;
        press_clear  = btn_clear & ~clear_prev_q;
    end

    // Next state: clear beats start beats lap, but only among presses the current state accepts
    always_comb begin
        state_d    = state_q;
        snap_load  = 1'b0;
        zero_count = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (press_start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (press_start) begin
                    state_d = ST_PAUSE;
                end else if (press_lap) begin
                    state_d   = ST_HOLD;
                    snap_load = 1'b1;
                end
            end
            ST_HOLD: begin
                if (press_start) begin
                    state_d = ST_PAUSE;
                end else if (press_lap) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (press_clear) begin
                    state_d    = ST_IDLE;
                    zero_count = 1'b1;
                end else if (press_start) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler: counts in RUN/HOLD only; a compare below the count lets it wrap through 2^24
    always_comb begin
        counting  = (state_q == ST_RUN) || (state_q == ST_HOLD);
        compare   = (div_override == 8'd0) ? TICK_DIV : {6'b0, div_override, 10'b0};
        presc_hit = counting && (presc_q == compare);
        presc_d   = presc_q;
        if (zero_count) begin
            presc_d = 24'd0;
        end else if (presc_hit) begin
            presc_d = 24'd0;
        end else if (counting) begin
            presc_d = presc_q + 24'd1;
        end
        tick_d = presc_hit;
    end

    // Ripple-carry BCD increment, 9:59.9 rolls over to 0:00.0
    always_comb begin
        carry0 = (d0_q == 4'd9);
        carry1 = carry0 && (d1_q == 4'd9);
        carry2 = carry1 && (d2_q == 4'd5);
        d0_d   = d0_q;
        d1_d   = d1_q;
        d2_d   = d2_q;
        d3_d   = d3_q;
        if (zero_count) begin
            d0_d = 4'd0;
            d1_d = 4'd0;
            d2_d = 4'd0;
            d3_d = 4'd0;
        end else if (presc_hit) begin
            d0_d = carry0 ? 4'd0 : d0_q + 4'd1;
            if (carry0) begin
                d1_d = (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
            end
            if (carry1) begin
                d2_d = (d2_q == 4'd5) ? 4'd0 : d2_q + 4'd1;
            end
            if (carry2) begin
                d3_d = (d3_q == 4'd9) ? 4'd0 : d3_q + 4'd1;
            end
        end
    end

    // Lap snapshot captures the pre-edge digits when RUN enters HOLD
    always_comb begin
        live_bcd  = {d3_q, d2_q, d1_q, d0_q};
        snap_d    = snap_load ? live_bcd : snap_q;
        shown_bcd = (state_q == ST_HOLD) ? snap_q : live_bcd;
    end

    // Scan scheduler: free-running in every state, one digit per SCAN_DIV+1 cycles
    always_comb begin
        scan_hit   = (scan_cnt_q == SCAN_DIV);
        scan_cnt_d = scan_hit ? 16'd0 : scan_cnt_q + 16'd1;
        scan_idx_d = scan_hit ? scan_idx_q + 2'd1 : scan_idx_q;
        digit_sel_d = 4'b0001 << scan_idx_q;
        case (scan_idx_q)
            2'd0:    digit_bcd_d = shown_bcd[3:0];
            2'd1:    digit_bcd_d = shown_bcd[7:4];
            2'd2:    digit_bcd_d = shown_bcd[11:8];
            default: digit_bcd_d = shown_bcd[15:12];
        endcase
    end

    // Status flags track the state being entered so they line up with the new state
    always_comb begin
        running_d  = (state_d == ST_RUN) || (state_d == ST_HOLD);
        lap_hold_d = (state_d == ST_HOLD);
    end

    // All state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_prev_q <= 1'b0;
            lap_prev_q   <= 1'b0;
            clear_prev_q <= 1'b0;
            state_q      <= ST_IDLE;
            presc_q      <= 24'd0;
            d0_q         <= 4'd0;
            d1_q         <= 4'd0;
            d2_q         <= 4'd0;
            d3_q         <= 4'd0;
            snap_q       <= 16'd0;
            scan_cnt_q   <= 16'd0;
            scan_idx_q   <= 2'd0;
            digit_sel_q  <= 4'b0001;
            digit_bcd_q  <= 4'd0;
            running_q    <= 1'b0;
            lap_hold_q   <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            start_prev_q <= start_prev_d;
            lap_prev_q   <= lap_prev_d;
            clear_prev_q <= clear_prev_d;
            state_q      <= state_d;
            presc_q      <= presc_d;
            d0_q         <= d0_d;
            d1_q         <= d1_d;
            d2_q         <= d2_d;
            d3_q         <= d3_d;
            snap_q       <= snap_d;
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            digit_sel_q  <= digit_sel_d;
            digit_bcd_q  <= digit_bcd_d;
            running_q    <= running_d;
            lap_hold_q   <= lap_hold_d;
            tick_q       <= tick_d;
        end
    end

    assign digit_sel = digit_sel_q;
    assign digit_bcd = digit_bcd_q;
    assign running   = running_q;
    assign lap_hold  = lap_hold_q;
    assign tick      = tick_q;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Controller that sequences the team's tick-counter and 7-segment datapath as a 4-digit stopwatch (M:SS.t).
- Owns the tick prescaler, a 4-digit BCD time register and a start/pause/lap/clear state machine.
- Owns the digit-scan scheduler that time-shares the single seg7 decoder across four digit enables.
- Sits between the board buttons/switches and the seg7 instance.

Parameters:
TICK_DIV, 24'd999_999, compare value for the tenths prescaler (period TICK_DIV+1 cycles; 10 Hz at 10 MHz)
SCAN_DIV, 16'd9_999, compare value for the digit-scan counter (period SCAN_DIV+1 cycles)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
btn_start  in  1  start/pause button; synchronous level, rising edge = press
btn_lap  in  1  lap button; synchronous level, rising edge = press
btn_clear  in  1  clear button; synchronous level, rising edge = press
div_override  in  8  0 = use TICK_DIV; nonzero = prescaler compare {6'b0, div_override, 10'b0}
digit_bcd  out  4  BCD value of the currently selected digit, to seg7
digit_sel  out  4  one-hot digit enable, bit0 = tenths, bit3 = minutes
running  out  1  high in RUN and HOLD
lap_hold  out  1  high in HOLD
tick  out  1  one-cycle pulse per tenths increment

Behaviour:
Clock and reset
- One clock, clk. Reset rst_n is asynchronous, active-low.
- On reset, any cycle or state:
  - state = IDLE
  - prescaler, scan counter, scan index, BCD digits and snapshot = 0
  - digit_sel = 4'b0001, digit_bcd = 0, running = 0, lap_hold = 0, tick = 0
- Button edge registers reset to 0, so a button held through reset release counts as a press on the first clock.

Press detection
- Press = input high this cycle and low in the registered previous cycle.
- Same-cycle priority: clear > start > lap. Only the highest-priority press that is valid in the current state acts; the others are dropped.

FSM: IDLE, RUN, HOLD, PAUSE
- IDLE: start -> RUN. Lap and clear are ignored.
- RUN: start -> PAUSE; lap -> HOLD, and the snapshot register loads the current BCD digits in the same edge.
- HOLD: lap -> RUN; start -> PAUSE. Counting continues throughout HOLD.
- PAUSE: start -> RUN; clear -> IDLE, zeroing the BCD digits and the prescaler. Lap is ignored.
- Clear is ignored in RUN and HOLD.

Prescaler
- 24-bit; counts only in RUN and HOLD; holds its value in PAUSE.
- compare = (div_override == 0) ? TICK_DIV : {6'b0, div_override, 10'b0}, evaluated every cycle.
- When prescaler == compare: prescaler <= 0 and the BCD value increments.
- If compare drops below the current count, the prescaler runs up to 2^24-1, wraps to 0 and then matches. This is accepted.
- tick is registered and high in the cycle the incremented BCD value first becomes visible.

BCD counter
- d0 0–9, d1 0–9, d2 0–5, d3 0–9, each with ripple carry.
- 9:59.9 followed by a tick gives 0:00.0; counting continues, no flag.

Scan scheduler
- 16-bit scan counter runs in every state.
- When scan counter == SCAN_DIV: scan counter <= 0 and index advances 0→1→2→3→0.
- digit_sel and digit_bcd are registered from the current index and source: 1-cycle latency after an index or digit change.
- Source is the snapshot in HOLD, otherwise the live digits.
- digit_sel is always exactly one-hot.

Outputs
- running and lap_hold are registered decodes of state, valid in the cycle after the transition edge.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-count, then release → all outputs at reset values immediately, with no clock edge required; digits stay 0.00.0 for 50 000 cycles with no press.
2. Count and rate (TICK_DIV=9, SCAN_DIV=3): press start, wait 1000 cycles → 100 tick pulses exactly 10 cycles apart; digits 0:10.0; running=1.
3. Wrap (TICK_DIV=0): start, run 6000 ticks → sequence passes 9:59.9 → 0:00.0; d2 never exceeds 5.
4. Lap (TICK_DIV=9): start, lap at 0:02.3 → lap_hold=1; scanned display shows 3,2,0,0 while tick continues; after 50 ticks press lap → live value 0:07.3 displayed.
5. Pause/clear and priority: pause at 0:01.4, then 100 cycles idle → value and prescaler frozen. Press start and clear in the same cycle → IDLE, zeroed. Press clear while RUN → ignored.
6. Override and scan: div_override=8'h01 → tick period 1025 cycles. With SCAN_DIV=3, digit_sel cycles 0001→0010→0100→1000 every 4 cycles, and digit_bcd matches the selected digit one cycle later.
